// File: rtl/bist_pattern_engine.sv
// Logic-BIST engine: 8-bit LFSR pattern source feeding a combinational CUT, with a 16-bit serial
// signature register compacting its response. Optional macro BIST_ALLZERO_PAT_EN appends an all-zero pattern.
module bist_pattern_engine #(
    parameter int               PAT_W   = 8,
    parameter int               SIG_W   = 16,
    parameter logic [PAT_W-1:0] SEED    = 8'h01,
    parameter int               NUM_PAT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic             resp_in,
    output logic [PAT_W-1:0] pat_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [8:0]       pat_cnt
);

`ifdef BIST_ALLZERO_PAT_EN
    localparam int TOTAL_PAT = NUM_PAT + 1;
`else
    localparam int TOTAL_PAT = NUM_PAT;
`endif

    localparam logic [8:0]       TOTAL_CNT = 9'(TOTAL_PAT);
    localparam logic [8:0]       LFSR_CNT  = 9'(NUM_PAT);
    localparam logic [SIG_W-1:0] SIG_POLY  = SIG_W'(16'h1021);
    // A zero seed would lock the LFSR at zero, so it is replaced by 1.
    localparam logic [PAT_W-1:0] SEED_EFF  = (SEED == {PAT_W{1'b0}}) ? PAT_W'(8'h01) : SEED;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_APPLY = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t     state;
    logic [8:0] cnt_next;

    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] p);
        return {p[PAT_W-2:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

    function automatic logic [SIG_W-1:0] sisr_next(input logic [SIG_W-1:0] sig, input logic resp);
        logic fb;
        fb = sig[SIG_W-1] ^ resp;
        return {sig[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : {SIG_W{1'b0}});
    endfunction

    assign cnt_next = pat_cnt + 9'd1;

    // Run controller: sequences seed/apply/compare and owns every output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pat_out   <= {PAT_W{1'b0}};
            signature <= {SIG_W{1'b0}};
            pat_cnt   <= 9'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else if (abort) begin
            state   <= ST_IDLE;
            pat_out <= {PAT_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SEED;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SEED: begin
                    pat_out   <= SEED_EFF;
                    signature <= {SIG_W{1'b0}};
                    pat_cnt   <= 9'd0;
                    pass      <= 1'b0;
                    state     <= ST_APPLY;
                end
                ST_APPLY: begin
                    // The CUT has had a full cycle to settle on pat_out, so capture now.
                    signature <= sisr_next(signature, resp_in);
                    pat_cnt   <= cnt_next;
                    if (cnt_next == TOTAL_CNT) begin
                        pat_out <= {PAT_W{1'b0}};
                        state   <= ST_CMP;
                    end else if (cnt_next >= LFSR_CNT) begin
                        pat_out <= {PAT_W{1'b0}};
                        state   <= ST_APPLY;
                    end else begin
                        pat_out <= lfsr_next(pat_out);
                        state   <= ST_APPLY;
                    end
                end
                ST_CMP: begin
                    pass  <= (signature == golden_sig);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (start) begin
                        state <= ST_SEED;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pat_out <= {PAT_W{1'b0}};
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Directed bench for bist_pattern_engine driving an OR8 CUT model (or stuck-at variants) on resp_in.
module tb_bist_pattern_engine;

`ifdef BIST_ALLZERO_PAT_EN
    localparam int  TOTAL  = 256;
    localparam logic SA1_PASS = 1'b0;
`else
    localparam int  TOTAL  = 255;
    localparam logic SA1_PASS = 1'b1;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] golden_sig;
    logic        resp_in;
    logic [7:0]  pat_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [8:0]  pat_cnt;

    logic [1:0]  mode;
    int          total;
    int          bad;
    int          cycles;
    logic [15:0] golden_ok;
    logic [15:0] first_sig;
    logic [7:0]  exp_pat [6];

    bist_pattern_engine dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .golden_sig(golden_sig), .resp_in(resp_in), .pat_out(pat_out),
        .busy(busy), .done(done), .pass(pass), .signature(signature), .pat_cnt(pat_cnt)
    );

    // mode 0: fault-free OR8, 1: output stuck-at-1, 2: output stuck-at-0
    assign resp_in = (mode == 2'd0) ? (|pat_out) : (mode == 2'd1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_sig(input logic [1:0] m);
        logic [7:0]  p;
        logic [7:0]  pat;
        logic [15:0] s;
        logic        r;
        p = 8'h01;
        s = 16'h0000;
        for (int i = 0; i < TOTAL; i++) begin
            pat = (i < 255) ? p : 8'h00;
            r   = (m == 2'd0) ? (|pat) : (m == 2'd1);
            s   = (s[15] ^ r) ? ((s << 1) ^ 16'h1021) : (s << 1);
            p   = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done; 1 is added for the start edge itself.
    task automatic wait_done(output int n);
        n = 1;
        for (int i = 0; i < 600; i++) begin
            if (done) break;
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_cnt(input logic [8:0] target);
        for (int i = 0; i < 600; i++) begin
            if (pat_cnt == target) break;
            @(posedge clk);
            #1;
        end
        check("cnt_timeout", {23'd0, pat_cnt}, {23'd0, target});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; golden_sig = 16'h0000; mode = 2'd0;
        exp_pat[0] = 8'h01; exp_pat[1] = 8'h02; exp_pat[2] = 8'h04;
        exp_pat[3] = 8'h08; exp_pat[4] = 8'h11; exp_pat[5] = 8'h23;
        golden_ok = ref_sig(2'd0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_pat_out", {24'd0, pat_out}, 32'd0);
        check("rst_signature", {16'd0, signature}, 32'd0);
        check("rst_pat_cnt", {23'd0, pat_cnt}, 32'd0);
        check("rst_flags", {29'd0, busy, done, pass}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First six APPLY patterns from seed 01
        pulse_start();
        check("seed_busy", {30'd0, busy, done}, 32'd2);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("pat_%0d", i + 1), {24'd0, pat_out}, {24'd0, exp_pat[i]});
        end
        check("apply_flags", {30'd0, busy, done}, 32'd2);
        check("apply_cnt", {23'd0, pat_cnt}, 32'd5);

        // Asynchronous reset mid-APPLY
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_pat_out", {24'd0, pat_out}, 32'd0);
        check("arst_sig_cnt", {7'd0, pat_cnt, signature}, 32'd0);
        check("arst_flags", {29'd0, busy, done, pass}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_idle", {30'd0, busy, done}, 32'd0);

        // Fault-free full run
        golden_sig = golden_ok;
        pulse_start();
        wait_done(cycles);
        check("ff_latency", cycles, TOTAL + 3);
        check("ff_pass", {31'd0, pass}, 32'd1);
        check("ff_cnt", {23'd0, pat_cnt}, TOTAL);
        check("ff_sig", {16'd0, signature}, {16'd0, golden_ok});
        check("ff_idle_outs", {23'd0, pat_out, busy}, 32'd0);
        first_sig = signature;

        // Restart from DONE reproduces the signature
        pulse_start();
        check("rerun_clears_done", {31'd0, done}, 32'd0);
        wait_done(cycles);
        check("rerun_sig", {16'd0, signature}, {16'd0, first_sig});
        check("rerun_pass", {31'd0, pass}, 32'd1);

        // Output stuck-at-1: only the all-zero pattern exposes it
        mode = 2'd1;
        pulse_start();
        wait_done(cycles);
        check("sa1_pass", {31'd0, pass}, {31'd0, SA1_PASS});
        check("sa1_sig", {16'd0, signature}, {16'd0, ref_sig(2'd1)});

        // Output stuck-at-0: signature never leaves zero
        mode = 2'd2;
        pulse_start();
        wait_done(cycles);
        check("sa0_pass", {31'd0, pass}, 32'd0);
        check("sa0_sig", {16'd0, signature}, 32'd0);

        // Abort at pattern 100, asserted together with start to exercise priority
        mode = 2'd0;
        pulse_start();
        wait_cnt(9'd100);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_flags", {30'd0, busy, done}, 32'd0);
        check("abort_pat_out", {24'd0, pat_out}, 32'd0);
        check("abort_cnt", {23'd0, pat_cnt}, 32'd100);
        @(posedge clk);
        #1;
        check("abort_stays_idle", {21'd0, pat_cnt, busy, done}, {21'd0, 9'd100, 2'b00});

        // start during APPLY is ignored
        pulse_start();
        wait_cnt(9'd10);
        pulse_start();
        check("start_in_apply_cnt", {23'd0, pat_cnt}, 32'd11);
        check("start_in_apply_busy", {31'd0, busy}, 32'd1);
        wait_done(cycles);
        check("start_in_apply_final", {23'd0, pat_cnt}, TOTAL);
        check("start_in_apply_pass", {31'd0, pass}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
